ws2812_receiver: RTL and testbench



---
 rtl/ws2812_pkg.sv | 18 +
 rtl/ws2812_edge_sync.sv | 30 +++
 rtl/ws2812_receiver.sv | 198 +++++++++++++++++++
 tb/tb_ws2812_receiver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared constants and state encoding for the WS2812 receive path.
package ws2812_pkg;
    localparam int WORD_BITS      = 24;
    localparam int T0H_CYC        = 20;
    localparam int T1H_CYC        = 40;
    localparam int T_THRESH_CYC   = 30;
    localparam int T_MIN_HIGH_CYC = 8;
    localparam int T_MAX_HIGH_CYC = 60;
    localparam int RESET_CYC      = 2500;
    localparam int PIX_W_DEF      = 8;

    typedef enum logic [1:0] {
        SYNC_WAIT,
        IDLE,
        HIGH,
        LOW
    } rx_state_t;
endpackage

// File: rtl/ws2812_edge_sync.sv
// Two-flop synchronizer for the asynchronous data line, followed by a
// registered previous-sample flop that yields single-cycle rise/fall strobes.
module ws2812_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);
    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;
endmodule

// File: rtl/ws2812_receiver.sv
// WS2812 pulse-width decoder: rebuilds 24-bit GRB words, flags frame gaps and
// timing errors. Define WS2812_FORWARD_EN to add the dout daisy-chain output.
//
// state     | meaning
// SYNC_WAIT | not armed; waiting for a full low reset gap
// IDLE      | armed, line low, no bits of the current word yet
// HIGH      | measuring a high pulse
// LOW       | between bits; watching for the next pulse or a reset gap
module ws2812_receiver
    import ws2812_pkg::*;
#(
    parameter int T_THRESH     = T_THRESH_CYC,
    parameter int T_MIN_HIGH   = T_MIN_HIGH_CYC,
    parameter int T_MAX_HIGH   = T_MAX_HIGH_CYC,
    parameter int RESET_CYCLES = RESET_CYC,
    parameter int PIX_W        = PIX_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 din,
    output logic [WORD_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic [PIX_W-1:0]     pixel_count,
    output logic                 frame_done,
    output logic                 bit_error,
    output logic                 synced
`ifdef WS2812_FORWARD_EN
    ,
    output logic                 dout
`endif
);
    localparam logic [7:0]  THRESH_W = 8'(T_THRESH);
    localparam logic [7:0]  MIN_W    = 8'(T_MIN_HIGH);
    localparam logic [7:0]  MAX_W    = 8'(T_MAX_HIGH);
    localparam logic [12:0] LOW_TC   = 13'(RESET_CYCLES - 1);
    localparam logic [4:0]  BIT_LAST = 5'(WORD_BITS - 1);

    logic level;
    logic rise;
    logic fall;

    rx_state_t              state, state_n;
    logic [6:0]             high_cnt, high_cnt_n;
    logic [12:0]            low_cnt, low_cnt_n;
    logic [4:0]             bit_cnt, bit_cnt_n;
    logic [WORD_BITS-2:0]   shreg, shreg_n;
    logic [WORD_BITS-1:0]   data_out_n;
    logic [PIX_W-1:0]       pixel_count_n;
    logic                   data_valid_n;
    logic                   frame_done_n;
    logic                   bit_error_n;
    logic                   synced_n;
    logic                   err;
    logic [7:0]             width;
    logic                   bit_val;

    ws2812_edge_sync u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (din),
        .level   (level),
        .rise    (rise),
        .fall    (fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= SYNC_WAIT;
            high_cnt    <= '0;
            low_cnt     <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            pixel_count <= '0;
            frame_done  <= 1'b0;
            bit_error   <= 1'b0;
            synced      <= 1'b0;
        end else begin
            state       <= state_n;
            high_cnt    <= high_cnt_n;
            low_cnt     <= low_cnt_n;
            bit_cnt     <= bit_cnt_n;
            shreg       <= shreg_n;
            data_out    <= data_out_n;
            data_valid  <= data_valid_n;
            pixel_count <= pixel_count_n;
            frame_done  <= frame_done_n;
            bit_error   <= bit_error_n;
            synced      <= synced_n;
        end
    end

    always_comb begin
        state_n       = state;
        high_cnt_n    = high_cnt;
        low_cnt_n     = low_cnt;
        bit_cnt_n     = bit_cnt;
        shreg_n       = shreg;
        data_out_n    = data_out;
        pixel_count_n = pixel_count;
        synced_n      = synced;
        data_valid_n  = 1'b0;
        frame_done_n  = 1'b0;
        bit_error_n   = 1'b0;
        err           = 1'b0;
        // high_cnt misses the rise cycle, so the true width is one more
        width         = {1'b0, high_cnt} + 8'd1;
        bit_val       = (width >= THRESH_W);

        case (state)
            SYNC_WAIT: begin
                if (level) begin
                    low_cnt_n = '0;
                end else if (low_cnt == LOW_TC) begin
                    state_n       = IDLE;
                    synced_n      = 1'b1;
                    low_cnt_n     = '0;
                    pixel_count_n = '0;
                end else if (low_cnt != '1) begin
                    low_cnt_n = low_cnt + 13'd1;
                end
            end
            IDLE: begin
                if (rise) begin
                    high_cnt_n = '0;
                    state_n    = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    if (width < MIN_W || width > MAX_W) begin
                        err = 1'b1;
                    end else begin
                        shreg_n   = {shreg[WORD_BITS-3:0], bit_val};
                        bit_cnt_n = bit_cnt + 5'd1;
                        low_cnt_n = '0;
                        state_n   = LOW;
                        if (bit_cnt == BIT_LAST) begin
                            data_out_n   = {shreg, bit_val};
                            data_valid_n = 1'b1;
                            bit_cnt_n    = '0;
                            shreg_n      = '0;
                            if (pixel_count != '1)
                                pixel_count_n = pixel_count + PIX_W'(1);
                        end
                    end
                end else if ({1'b0, high_cnt} > MAX_W) begin
                    err = 1'b1;
                end else if (high_cnt != '1) begin
                    high_cnt_n = high_cnt + 7'd1;
                end
            end
            LOW: begin
                if (rise) begin
                    high_cnt_n = '0;
                    state_n    = HIGH;
                end else if (low_cnt == LOW_TC) begin
                    frame_done_n  = 1'b1;
                    bit_error_n   = (bit_cnt != 5'd0);
                    pixel_count_n = '0;
                    bit_cnt_n     = '0;
                    shreg_n       = '0;
                    low_cnt_n     = '0;
                    state_n       = IDLE;
                end else if (low_cnt != '1) begin
                    low_cnt_n = low_cnt + 13'd1;
                end
            end
            default: state_n = SYNC_WAIT;
        endcase

        if (err) begin
            bit_error_n = 1'b1;
            synced_n    = 1'b0;
            bit_cnt_n   = '0;
            shreg_n     = '0;
            low_cnt_n   = '0;
            state_n     = SYNC_WAIT;
        end
    end

`ifdef WS2812_FORWARD_EN
    logic fwd_en;

    // Opens on pixel 0 completion, when the line is guaranteed low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            fwd_en <= 1'b0;
        else if (bit_error_n || frame_done_n || !synced_n)
            fwd_en <= 1'b0;
        else if (data_valid_n && pixel_count == '0)
            fwd_en <= 1'b1;
    end

    assign dout = fwd_en & level;
`endif
endmodule

// File: tb/tb_ws2812_receiver.sv
// Directed self-checking bench for ws2812_receiver.
module tb_ws2812_receiver;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        din;
    logic [23:0] data_out;
    logic        data_valid;
    logic [7:0]  pixel_count;
    logic        frame_done;
    logic        bit_error;
    logic        synced;
`ifdef WS2812_FORWARD_EN
    logic        dout;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_dv, n_fd, n_be, n_coinc, n_dout_hi, n_fwd_diff;
    logic [23:0] cap [0:7];
    logic [7:0]  pc_at_valid;
    logic        din_now;
    logic        din_prev = 1'b0;

    always #5 clk = ~clk;

    ws2812_receiver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .din         (din),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .pixel_count (pixel_count),
        .frame_done  (frame_done),
        .bit_error   (bit_error),
        .synced      (synced)
`ifdef WS2812_FORWARD_EN
        ,
        .dout        (dout)
`endif
    );

    // Event monitor: samples outputs 1 ns after each rising edge.
    always @(posedge clk) begin
        din_now = din;
        #1;
        if (data_valid) begin
            if (n_dv < 8) cap[n_dv] = data_out;
            n_dv++;
            pc_at_valid = pixel_count;
        end
        if (frame_done) n_fd++;
        if (bit_error) n_be++;
        if (frame_done && bit_error) n_coinc++;
`ifdef WS2812_FORWARD_EN
        if (dout) n_dout_hi++;
        if (dout !== din_prev) n_fwd_diff++;
`endif
        din_prev = din_now;
    end

    task automatic clr();
        n_dv = 0; n_fd = 0; n_be = 0; n_coinc = 0; n_dout_hi = 0; n_fwd_diff = 0;
    endtask

    task automatic drive_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_pulse(input int hi, input int period);
        din = 1'b1;
        repeat (hi) @(negedge clk);
        din = 1'b0;
        repeat (period - hi) @(negedge clk);
    endtask

    task automatic send_bits(input logic [23:0] w, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_pulse(w[i] ? 40 : 20, 62);
    endtask

    task automatic test_reset();
        n_checks++; if (data_out !== 24'h0) begin n_fail++; $display("FAIL rst_data: got %h expected 000000", data_out); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dv: got %b expected 0", data_valid); end
        n_checks++; if (pixel_count !== 8'd0) begin n_fail++; $display("FAIL rst_pc: got %0d expected 0", pixel_count); end
        n_checks++; if (frame_done !== 1'b0 || bit_error !== 1'b0) begin n_fail++; $display("FAIL rst_pulses: got fd=%b be=%b expected 0 0", frame_done, bit_error); end
        n_checks++; if (synced !== 1'b0) begin n_fail++; $display("FAIL rst_synced: got %b expected 0", synced); end
`ifdef WS2812_FORWARD_EN
        n_checks++; if (dout !== 1'b0) begin n_fail++; $display("FAIL rst_dout: got %b expected 0", dout); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        drive_low(2400);
        n_checks++; if (synced !== 1'b0) begin n_fail++; $display("FAIL gap_short_synced: got %b expected 0", synced); end
        drive_low(200);
        n_checks++; if (synced !== 1'b1) begin n_fail++; $display("FAIL gap_synced: got %b expected 1", synced); end
    endtask

    task automatic test_word();
        clr();
        send_bits(24'hA5C3F0 >> 1, 23);
        din = 1'b1;
        repeat (20) @(negedge clk);
        din = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early: got %b expected 0", data_valid); end
        @(posedge clk); #1;
        n_checks++; if (data_valid !== 1'b1) begin n_fail++; $display("FAIL lat_dv: got %b expected 1", data_valid); end
        n_checks++; if (data_out !== 24'hA5C3F0) begin n_fail++; $display("FAIL word_data: got %h expected a5c3f0", data_out); end
        n_checks++; if (pixel_count !== 8'd1) begin n_fail++; $display("FAIL word_pc: got %0d expected 1", pixel_count); end
        @(negedge clk);
        drive_low(3000);
        n_checks++; if (n_dv !== 1) begin n_fail++; $display("FAIL word_ndv: got %0d expected 1", n_dv); end
        n_checks++; if (n_fd !== 1) begin n_fail++; $display("FAIL word_nfd: got %0d expected 1", n_fd); end
        n_checks++; if (n_be !== 0) begin n_fail++; $display("FAIL word_nbe: got %0d expected 0", n_be); end
        n_checks++; if (pixel_count !== 8'd0) begin n_fail++; $display("FAIL word_pc_clr: got %0d expected 0", pixel_count); end
    endtask

    task automatic test_loopback();
        clr();
        for (int f = 0; f < 3; f++) begin
            send_bits(24'h00FF00, 24);
            drive_low(3000);
        end
        n_checks++; if (n_dv !== 3) begin n_fail++; $display("FAIL loop_ndv: got %0d expected 3", n_dv); end
        n_checks++; if (n_fd !== 3) begin n_fail++; $display("FAIL loop_nfd: got %0d expected 3", n_fd); end
        n_checks++; if (n_be !== 0) begin n_fail++; $display("FAIL loop_nbe: got %0d expected 0", n_be); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (cap[i] !== 24'h00FF00) begin n_fail++; $display("FAIL loop_data%0d: got %h expected 00ff00", i, cap[i]); end
        end
    endtask

    task automatic test_boundary();
        clr();
        send_pulse(8, 62);
        send_pulse(29, 62);
        send_pulse(30, 62);
        send_pulse(60, 62);
        send_bits(24'h012345, 20);
        drive_low(3000);
        n_checks++; if (n_dv !== 1 || cap[0] !== 24'h312345) begin n_fail++; $display("FAIL bnd_word: got n=%0d data=%h expected 1 312345", n_dv, cap[0]); end
        n_checks++; if (n_be !== 0 || n_fd !== 1) begin n_fail++; $display("FAIL bnd_events: got be=%0d fd=%0d expected 0 1", n_be, n_fd); end
        clr();
        send_pulse(7, 62);
        n_checks++; if (n_be !== 1 || synced !== 1'b0) begin n_fail++; $display("FAIL bnd_w7: got be=%0d synced=%b expected 1 0", n_be, synced); end
        drive_low(3000);
        n_checks++; if (synced !== 1'b1 || n_fd !== 0) begin n_fail++; $display("FAIL bnd_resync: got synced=%b fd=%0d expected 1 0", synced, n_fd); end
    endtask

    task automatic test_glitch();
        clr();
        send_bits(24'h0002AA, 10);
        send_pulse(5, 62);
        n_checks++; if (n_be !== 1) begin n_fail++; $display("FAIL glitch_be: got %0d expected 1", n_be); end
        n_checks++; if (synced !== 1'b0) begin n_fail++; $display("FAIL glitch_synced: got %b expected 0", synced); end
        send_bits(24'h0000FF, 8);
        drive_low(1000);
        n_checks++; if (synced !== 1'b0) begin n_fail++; $display("FAIL glitch_early_sync: got %b expected 0", synced); end
        drive_low(2000);
        n_checks++; if (synced !== 1'b1 || n_dv !== 0 || n_fd !== 0) begin n_fail++; $display("FAIL glitch_resync: got synced=%b dv=%0d fd=%0d expected 1 0 0", synced, n_dv, n_fd); end
        send_bits(24'h5A5A5A, 24);
        drive_low(3000);
        n_checks++; if (n_dv !== 1 || cap[0] !== 24'h5A5A5A || pc_at_valid !== 8'd1) begin n_fail++; $display("FAIL glitch_next: got n=%0d data=%h pc=%0d expected 1 5a5a5a 1", n_dv, cap[0], pc_at_valid); end
        n_checks++; if (n_be !== 1 || n_fd !== 1) begin n_fail++; $display("FAIL glitch_events: got be=%0d fd=%0d expected 1 1", n_be, n_fd); end
    endtask

    task automatic test_stuck_high();
        clr();
        din = 1'b1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #1;
            if (i == 64) begin
                n_checks++; if (bit_error !== 1'b0) begin n_fail++; $display("FAIL stuck_early: got %b expected 0", bit_error); end
            end
            if (i == 65) begin
                n_checks++; if (bit_error !== 1'b1) begin n_fail++; $display("FAIL stuck_be: got %b expected 1", bit_error); end
            end
        end
        n_checks++; if (synced !== 1'b0 || n_be !== 1) begin n_fail++; $display("FAIL stuck_state: got synced=%b be=%0d expected 0 1", synced, n_be); end
        @(negedge clk);
        drive_low(3000);
        n_checks++; if (synced !== 1'b1 || n_fd !== 0) begin n_fail++; $display("FAIL stuck_resync: got synced=%b fd=%0d expected 1 0", synced, n_fd); end
    endtask

    task automatic test_partial();
        clr();
        send_bits(24'h000ABC, 12);
        drive_low(3000);
        n_checks++; if (n_coinc !== 1) begin n_fail++; $display("FAIL part_coinc: got %0d expected 1", n_coinc); end
        n_checks++; if (n_dv !== 0) begin n_fail++; $display("FAIL part_dv: got %0d expected 0", n_dv); end
        n_checks++; if (n_fd !== 1 || n_be !== 1) begin n_fail++; $display("FAIL part_events: got fd=%0d be=%0d expected 1 1", n_fd, n_be); end
        n_checks++; if (pixel_count !== 8'd0 || synced !== 1'b1) begin n_fail++; $display("FAIL part_state: got pc=%0d synced=%b expected 0 1", pixel_count, synced); end
    endtask

`ifdef WS2812_FORWARD_EN
    task automatic test_forward();
        clr();
        send_bits(24'h112233, 24);
        n_checks++; if (n_dout_hi !== 0 || n_dv !== 1) begin n_fail++; $display("FAIL fwd_pix0: got dout_hi=%0d dv=%0d expected 0 1", n_dout_hi, n_dv); end
        clr();
        send_bits(24'h445566, 24);
        n_checks++; if (pixel_count !== 8'd2) begin n_fail++; $display("FAIL fwd_pc: got %0d expected 2", pixel_count); end
        drive_low(3000);
        n_checks++; if (n_dout_hi !== 680) begin n_fail++; $display("FAIL fwd_hi: got %0d expected 680", n_dout_hi); end
        n_checks++; if (n_fwd_diff !== 0) begin n_fail++; $display("FAIL fwd_delay: got %0d differing cycles expected 0", n_fwd_diff); end
        n_checks++; if (n_fd !== 1 || dout !== 1'b0) begin n_fail++; $display("FAIL fwd_end: got fd=%0d dout=%b expected 1 0", n_fd, dout); end
        clr();
        send_bits(24'h778899, 24);
        n_checks++; if (n_dout_hi !== 0) begin n_fail++; $display("FAIL fwd_newframe: got %0d expected 0", n_dout_hi); end
        drive_low(3000);
    endtask
`endif

    task automatic test_reset_mid();
        clr();
        send_bits(24'h0F0F0F, 24);
        send_bits(24'hF0F0F0, 24);
        n_checks++; if (pixel_count !== 8'd2 || data_out !== 24'hF0F0F0) begin n_fail++; $display("FAIL mid_pre: got pc=%0d data=%h expected 2 f0f0f0", pixel_count, data_out); end
        send_bits(24'h000081, 8);
        din = 1'b1;
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_checks++; if (pixel_count !== 8'd0 || data_out !== 24'h0 || synced !== 1'b0) begin n_fail++; $display("FAIL mid_rst: got pc=%0d data=%h synced=%b expected 0 000000 0", pixel_count, data_out, synced); end
        @(negedge clk);
        din = 1'b0;
        reset_n = 1'b1;
        drive_low(3000);
        n_checks++; if (synced !== 1'b1) begin n_fail++; $display("FAIL mid_resync: got %b expected 1", synced); end
    endtask

    initial begin
        reset_n = 1'b0;
        din = 1'b0;
        clr();
        repeat (5) @(negedge clk);
        test_reset();
        test_word();
        test_loopback();
        test_boundary();
        test_glitch();
        test_stuck_high();
        test_partial();
`ifdef WS2812_FORWARD_EN
        test_forward();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
